firebird7_in_gate2_edt_sol_monitor: RTL

FIREBIRD7_IN_GATE2_EDT_SOL_MONITOR -- requirements
Module: firebird7_in_gate2_edt_sol_monitor

---
 rtl/firebird7_in_gate2_edt_sol_monitor.sv | 117 +++++++++++
 1 files changed

// File: rtl/firebird7_in_gate2_edt_sol_monitor.sv
// EDT signature-on-line error monitor: counts masked channel miscompares and flags threshold trips.
// Latency: a chan_err strobe shows in sol_count/sol_fail one edge later; TDR controls take 2 extra cycles to synchronize.
// Backpressure: none; the monitor samples every cycle and never stalls its source.
module firebird7_in_gate2_edt_sol_monitor (
  input  logic        edt_clock,
  input  logic        edt_reset,
  input  logic [1:0]  sol_mask,
  input  logic [14:0] sol_thresh,
  input  logic        sol_init,
  input  logic        sol_mode,
  input  logic        reset_b,
  input  logic        jam_edt_channels_in,
  input  logic        chan_valid,
  input  logic [1:0]  chan_err,
  input  logic        edt_update,
  output logic [14:0] sol_count,
  output logic [14:0] sol_peak,
  output logic        sol_fail,
  output logic        sol_active,
  output logic        edt_jam
);

  typedef enum logic [1:0] {IDLE, RUN, TRIP} state_t;

  localparam int TW = 21;
  localparam logic [14:0] CNT_MAX = 15'h7FFF;

  logic [TW-1:0] tdr_raw;
  logic [TW-1:0] sync1;
  logic [TW-1:0] sync2;

  logic [1:0]  mask_s;
  logic [14:0] thresh_s;
  logic        init_s;
  logic        mode_s;
  logic        reset_b_s;
  logic        jam_s;
  logic        init_d;
  logic        init_rise;

  state_t      state;
  logic [1:0]  inc;
  logic [15:0] sum;
  logic [14:0] cnt_next;
  logic [14:0] peak_next;
  logic        window_close;

  assign tdr_raw = {sol_mask, sol_thresh, sol_init, sol_mode, reset_b, jam_edt_channels_in};
  assign {mask_s, thresh_s, init_s, mode_s, reset_b_s, jam_s} = sync2;

  // Two-flop synchronizer for all quasi-static TDR fields, plus the init edge-detect history flop.
  always_ff @(posedge edt_clock or posedge edt_reset) begin
    if (edt_reset) begin
      sync1  <= '0;
      sync2  <= '0;
      init_d <= 1'b0;
    end else begin
      sync1  <= tdr_raw;
      sync2  <= sync1;
      init_d <= init_s;
    end
  end

  assign init_rise  = init_s & ~init_d;
  assign edt_jam    = jam_s;
  assign sol_active = (state == RUN);

  // Next-count datapath: masked popcount, saturating add, and window roll-over.
  always_comb begin
    inc          = 2'd0;
    sum          = 16'd0;
    cnt_next     = sol_count;
    peak_next    = sol_peak;
    window_close = 1'b0;
    if (chan_valid && !jam_s && state != IDLE) begin
      inc = {1'b0, chan_err[0] & ~mask_s[0]} + {1'b0, chan_err[1] & ~mask_s[1]};
    end
    sum = {1'b0, sol_count} + {14'd0, inc};
    window_close = mode_s && edt_update;
    if (window_close) begin
      // The boundary cycle's own errors open the new window.
      cnt_next  = {13'd0, inc};
      peak_next = (sol_count > sol_peak) ? sol_count : sol_peak;
    end else begin
      cnt_next = sum[15] ? CNT_MAX : sum[14:0];
    end
  end

  // Monitor FSM with counters: reset_b_s dominates, then init re-arm, then normal counting.
  always_ff @(posedge edt_clock or posedge edt_reset) begin
    if (edt_reset) begin
      state     <= IDLE;
      sol_count <= '0;
      sol_peak  <= '0;
      sol_fail  <= 1'b0;
    end else if (!reset_b_s) begin
      state     <= IDLE;
      sol_count <= '0;
      sol_peak  <= '0;
      sol_fail  <= 1'b0;
    end else if (init_rise) begin
      // Re-arm wins over a coincident edt_update.
      state     <= RUN;
      sol_count <= '0;
      sol_peak  <= '0;
      sol_fail  <= 1'b0;
    end else if (state != IDLE) begin
      sol_count <= cnt_next;
      sol_peak  <= peak_next;
      if (thresh_s != 15'd0 && cnt_next >= thresh_s) begin
        sol_fail <= 1'b1;
        state    <= TRIP;
      end
    end
  end

endmodule
